// File: rtl/mcp3008_responder.sv
// mcp3008_responder
//   Emulates the MCP3008 SPI slave so the ADC command/readout path can be
//   exercised in-FPGA without the ADC. The SPI pins are oversampled by clk,
//   which must run at least 8x the SPI clock.
//
// Ports
//   clk           in   system clock
//   rst_n         in   synchronous reset, active low
//   ch_data       in   [79:0] channel values, ch_data[10*k+9:10*k] = channel k
//   mcp_dclk      in   SPI clock from the initiator (async)
//   mcp_cs_n      in   chip select, active low (async)
//   mcp_din       in   command bits from the initiator (async)
//   mcp_dout      out  response data, 0 whenever mcp_dout_oe is 0
//   mcp_dout_oe   out  output enable for the dout pad
//   conv_done     out  1-clk pulse when B0 (MSB-first) is placed on mcp_dout
//   conv_channel  out  [2:0] channel from the last command
//   conv_sgl      out  SGL/DIFF bit from the last command
//   frame_err     out  1-clk pulse when cs_n rises before B0 was driven
//
// Parameters
//   SYNC_STAGES   synchronizer depth on the three SPI pins (2..3)
//   LSB_TAIL      1: repeat B1..B9 LSB-first after B0; 0: drive 0 after B0
module mcp3008_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int LSB_TAIL    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [79:0] ch_data,
    input  logic        mcp_dclk,
    input  logic        mcp_cs_n,
    input  logic        mcp_din,
    output logic        mcp_dout,
    output logic        mcp_dout_oe,
    output logic        conv_done,
    output logic [2:0]  conv_channel,
    output logic        conv_sgl,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_CMD, S_SAMPLE, S_MSB, S_LSB, S_TAIL
    } state_t;

    logic [SYNC_STAGES-1:0] dclk_sync_q, dclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q,  din_sync_d;
    logic                   dclk_prev_q, dclk_prev_d;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [9:0]  shreg_q, shreg_d;
    logic        mcp_dout_q, mcp_dout_d;
    logic        mcp_dout_oe_q, mcp_dout_oe_d;
    logic        conv_done_q, conv_done_d;
    logic        frame_err_q, frame_err_d;
    logic [2:0]  conv_channel_q, conv_channel_d;
    logic        conv_sgl_q, conv_sgl_d;

    logic        dclk_s, cs_s, din_s, rise, fall;
    logic [2:0]  sel;
    logic [9:0]  ch_words [8];

    for (genvar k = 0; k < 8; k++) begin : g_words
        assign ch_words[k] = ch_data[10*k +: 10];
    end

    // Stage: pin synchronizers and edge strobes
    always_comb begin
        dclk_sync_d = {dclk_sync_q[SYNC_STAGES-2:0], mcp_dclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   mcp_cs_n};
        din_sync_d  = {din_sync_q[SYNC_STAGES-2:0],  mcp_din};
        dclk_s      = dclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        din_s       = din_sync_q[SYNC_STAGES-1];
        dclk_prev_d = dclk_s;
        rise        = dclk_s & ~dclk_prev_q;
        fall        = ~dclk_s & dclk_prev_q;
    end

    // Stage: frame state machine
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cmd_d          = cmd_q;
        shreg_d        = shreg_q;
        mcp_dout_d     = mcp_dout_q;
        mcp_dout_oe_d  = mcp_dout_oe_q;
        conv_done_d    = 1'b0;
        frame_err_d    = 1'b0;
        conv_channel_d = conv_channel_q;
        conv_sgl_d     = conv_sgl_q;
        sel            = {cmd_q[1:0], din_s};

        if (cs_s) begin
            // Deselect beats any dclk edge seen in the same cycle.
            state_d       = S_IDLE;
            mcp_dout_oe_d = 1'b0;
            mcp_dout_d    = 1'b0;
            // B0 has not been driven yet in any of these states.
            if (state_q == S_CMD || state_q == S_SAMPLE || state_q == S_MSB)
                frame_err_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d       = S_WAIT_START;
                    mcp_dout_oe_d = 1'b1;
                    mcp_dout_d    = 1'b0;
                end
                S_WAIT_START: begin
                    if (rise && din_s) begin
                        state_d = S_CMD;
                        cnt_d   = 4'd0;
                    end
                end
                S_CMD: begin
                    if (rise) begin
                        // cmd_q collects SGL, D2, D1; D0 arrives live on din_s.
                        cmd_d = {cmd_q[1:0], din_s};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd3) begin
                            conv_sgl_d     = cmd_q[2];
                            conv_channel_d = sel;
                            shreg_d        = ch_words[sel];
                            state_d        = S_SAMPLE;
                            cnt_d          = 4'd0;
                        end
                    end
                end
                S_SAMPLE: begin
                    if (fall) begin
                        if (cnt_q == 4'd0) begin
                            cnt_d = 4'd1;
                        end else begin
                            mcp_dout_d = 1'b0;
                            state_d    = S_MSB;
                            cnt_d      = 4'd9;
                        end
                    end
                end
                S_MSB: begin
                    if (fall) begin
                        mcp_dout_d = shreg_q[cnt_q];
                        if (cnt_q == 4'd0) begin
                            conv_done_d = 1'b1;
                            state_d     = (LSB_TAIL != 0) ? S_LSB : S_TAIL;
                            cnt_d       = 4'd1;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                S_LSB: begin
                    if (fall) begin
                        mcp_dout_d = shreg_q[cnt_q];
                        if (cnt_q == 4'd9) state_d = S_TAIL;
                        else               cnt_d   = cnt_q + 4'd1;
                    end
                end
                S_TAIL: begin
                    if (fall) mcp_dout_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Stage: registered state and outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dclk_sync_q    <= '0;
            cs_sync_q      <= '1;
            din_sync_q     <= '0;
            dclk_prev_q    <= 1'b0;
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            cmd_q          <= 3'd0;
            mcp_dout_q     <= 1'b0;
            mcp_dout_oe_q  <= 1'b0;
            conv_done_q    <= 1'b0;
            frame_err_q    <= 1'b0;
            conv_channel_q <= 3'd0;
            conv_sgl_q     <= 1'b0;
        end else begin
            dclk_sync_q    <= dclk_sync_d;
            cs_sync_q      <= cs_sync_d;
            din_sync_q     <= din_sync_d;
            dclk_prev_q    <= dclk_prev_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cmd_q          <= cmd_d;
            mcp_dout_q     <= mcp_dout_d;
            mcp_dout_oe_q  <= mcp_dout_oe_d;
            conv_done_q    <= conv_done_d;
            frame_err_q    <= frame_err_d;
            conv_channel_q <= conv_channel_d;
            conv_sgl_q     <= conv_sgl_d;
        end
    end

    // Data word: only loaded on the D0 capture, so no reset needed.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign mcp_dout     = mcp_dout_q;
    assign mcp_dout_oe  = mcp_dout_oe_q;
    assign conv_done    = conv_done_q;
    assign frame_err    = frame_err_q;
    assign conv_channel = conv_channel_q;
    assign conv_sgl     = conv_sgl_q;

endmodule
